// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter requester: FSM state encoding.
package arb_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_wdog_counter.sv
// Counts consecutive ungranted request cycles; saturates at TIMEOUT.
module arb_wdog_counter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT     = CW'(TIMEOUT);
  localparam logic [CW-1:0] LIMIT_M1  = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // Asserted in the cycle whose increment brings the count to TIMEOUT.
  assign tc = inc && (count == LIMIT_M1);

endmodule

// File: rtl/arb_requester.sv
// Issues a request to one arbiter port and consumes job_len+1 granted beats,
// aborting if the grant is withheld for TIMEOUT consecutive cycles.
module arb_requester
  import arb_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  input  logic [LEN_WIDTH-1:0] job_len,
  output logic                 job_ready,
  output logic                 request,
  input  logic                 grant,
  output logic                 beat,
  output logic                 done,
  output logic                 timeout,
  output logic                 busy
);

  arb_state_e           state, state_next;
  logic [LEN_WIDTH-1:0] remaining, remaining_next;
  logic                 done_next, timeout_next;
  logic                 wd_clear, wd_inc, wd_tc;

  assign job_ready = (state == IDLE);
  assign busy      = ~job_ready;
  assign request   = (state != IDLE);
  // A grant arriving after release is a lagging arbiter grant and is ignored.
  assign beat      = request && grant;
  assign wd_inc    = request && !grant;

  arb_wdog_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .clear(wd_clear),
    .inc  (wd_inc),
    .tc   (wd_tc)
  );

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    done_next      = 1'b0;
    timeout_next   = 1'b0;
    wd_clear       = 1'b0;
    unique case (state)
      IDLE: begin
        if (job_valid) begin
          state_next     = WAIT;
          remaining_next = job_len;
          wd_clear       = 1'b1;
        end
      end
      default: begin
        if (beat) begin
          wd_clear = 1'b1;
          if (remaining == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            remaining_next = remaining - 1'b1;
            state_next     = XFER;
          end
        end else if (wd_tc) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end else begin
          state_next = WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      done      <= done_next;
      timeout   <= timeout_next;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: cycle model feeds a scoreboard queue.
module tb_arb_requester;

  localparam int unsigned LEN_WIDTH = 8;
  localparam int unsigned TIMEOUT   = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 job_valid = 1'b0;
  logic [LEN_WIDTH-1:0] job_len = '0;
  logic                 grant = 1'b0;
  logic                 job_ready, request, beat, done, timeout, busy;

  arb_requester #(
    .LEN_WIDTH(LEN_WIDTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .job_valid(job_valid),
    .job_len  (job_len),
    .job_ready(job_ready),
    .request  (request),
    .grant    (grant),
    .beat     (beat),
    .done     (done),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic req;
    logic ready;
    logic beat;
    logic done;
    logic to;
    int   st;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // model state: 0 idle, 1 wait, 2 xfer
  int             m_state = 0;
  logic [7:0]     m_rem   = '0;
  int             m_wait  = 0;
  logic           m_done  = 1'b0;
  logic           m_to    = 1'b0;
  logic           m_req_prev = 1'b0;

  int cyc, obs_req, obs_beat, obs_done, obs_to, done_at;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_obs();
    cyc = 0; obs_req = 0; obs_beat = 0; obs_done = 0; obs_to = 0; done_at = -1;
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] len, input logic g);
    exp_t e, o;
    @(negedge clk);
    rst = r; job_valid = v; job_len = len; grant = g;
    e.req   = (m_state != 0);
    e.ready = (m_state == 0);
    e.beat  = e.req && g;
    e.done  = m_done;
    e.to    = m_to;
    e.st    = m_state;
    sb.push_back(e);
    #1;
    o = sb.pop_front();
    check("request", 32'(request), 32'(o.req));
    check("job_ready", 32'(job_ready), 32'(o.ready));
    check("busy", 32'(busy), 32'(!o.ready));
    check("beat", 32'(beat), 32'(o.beat));
    check("done", 32'(done), 32'(o.done));
    check("timeout", 32'(timeout), 32'(o.to));
    check("state", 32'(dut.state), 32'(o.st));
    if (request) obs_req++;
    if (beat) obs_beat++;
    if (done) begin obs_done++; done_at = cyc; end
    if (timeout) obs_to++;
    cyc++;
    @(posedge clk);
    if (r) begin
      m_state = 0; m_rem = '0; m_wait = 0; m_done = 1'b0; m_to = 1'b0;
    end else begin
      m_done = 1'b0; m_to = 1'b0;
      if (m_state == 0) begin
        if (v) begin m_state = 1; m_rem = len; m_wait = 0; end
      end else if (g) begin
        m_wait = 0;
        if (m_rem == 0) begin m_state = 0; m_done = 1'b1; end
        else begin m_rem = m_rem - 8'd1; m_state = 2; end
      end else begin
        m_wait++;
        if (m_wait >= int'(TIMEOUT)) begin m_state = 0; m_to = 1'b1; end
        else m_state = 1;
      end
    end
    m_req_prev = e.req;
  endtask

  logic g3 [13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    clr_obs();
    repeat (3) step(1'b1, 1'b0, 8'd0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 8'd0, 1'b1);

    // job_len=3, grant follows request with one cycle lag
    clr_obs();
    step(1'b0, 1'b1, 8'd3, 1'b0);
    repeat (7) step(1'b0, 1'b0, 8'd0, m_req_prev);
    check("s1_req_cycles", 32'(obs_req), 32'd5);
    check("s1_beats", 32'(obs_beat), 32'd4);
    check("s1_dones", 32'(obs_done), 32'd1);
    check("s1_done_cycle", 32'(done_at), 32'd6);
    // fresh single-beat job after the lagging grant
    clr_obs();
    step(1'b0, 1'b1, 8'd0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    check("s1b_beats", 32'(obs_beat), 32'd1);
    check("s1b_done_cycle", 32'(done_at), 32'd2);

    // grant never arrives
    clr_obs();
    step(1'b0, 1'b1, 8'd0, 1'b0);
    repeat (70) step(1'b0, 1'b0, 8'd0, 1'b0);
    check("s2_req_cycles", 32'(obs_req), TIMEOUT);
    check("s2_timeouts", 32'(obs_to), 32'd1);
    check("s2_beats", 32'(obs_beat), 32'd0);
    check("s2_dones", 32'(obs_done), 32'd0);

    // grant gap of three cycles after two beats
    clr_obs();
    for (int i = 0; i < 13; i++) step(1'b0, (i == 0), 8'd5, g3[i]);
    check("s3_beats", 32'(obs_beat), 32'd6);
    check("s3_dones", 32'(obs_done), 32'd1);
    check("s3_done_cycle", 32'(done_at), 32'd11);

    // reset mid-job after two of eight beats
    clr_obs();
    step(1'b0, 1'b1, 8'd7, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b1, 1'b0, 8'd0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 8'd0, 1'b1);
    check("s4_dones", 32'(obs_done), 32'd0);
    check("s4_timeouts", 32'(obs_to), 32'd0);

    // job_valid held high: back-to-back two-beat jobs
    clr_obs();
    repeat (13) step(1'b0, 1'b1, 8'd1, 1'b1);
    check("s5_dones", 32'(obs_done), 32'd4);
    check("s5_beats", 32'(obs_beat), 32'd8);
    repeat (4) step(1'b0, 1'b0, 8'd0, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
